// File: rtl/mem_param_rw_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mem_param_rw_pkg
//  Description : Shared types for the parametrised single-port memory and
//                its environment. The request/response structs use the
//                default 32-bit x 16-word geometry. The RTL builds its own
//                width-matched response type from the same field layout.
//  Revision    : 1.0  initial release
// ============================================================================
package mem_param_rw_pkg;

    localparam int MAX_RD_LAT = 4;

    localparam int PKG_WIDTH  = 32;
    localparam int PKG_DEPTH  = 16;
    localparam int PKG_ADDR_W = $clog2(PKG_DEPTH);
    localparam int PKG_BE_W   = PKG_WIDTH / 8;

    typedef struct packed {
        logic                  we;
        logic [PKG_ADDR_W-1:0] addr;
        logic [PKG_WIDTH-1:0]  wdata;
        logic [PKG_BE_W-1:0]   be;
    } mem_req_t;

    typedef struct packed {
        logic [PKG_WIDTH-1:0] rdata;
        logic                 err;
    } mem_rsp_t;

    typedef enum logic [0:0] {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } mem_state_e;

endpackage
`default_nettype wire

// File: rtl/mem_rsp_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : mem_rsp_fifo
//  Description : Synchronous FIFO of response records with occupancy count.
//                The depth does not need to be a power of two.
//                The caller must never push when the FIFO is full or pop
//                when it is empty. The memory's outstanding counter already
//                guarantees both conditions.
//  Ports       : clk, rst_n        clock / async active-low reset
//                i_push, i_push_data  enqueue strobe and record
//                i_pop             dequeue strobe (head advances)
//                o_head            oldest record (valid when o_count != 0)
//                o_count           current occupancy
//  Revision    : 1.0  initial release
// ============================================================================
module mem_rsp_fifo
    import mem_param_rw_pkg::*;
#(
    parameter type T     = mem_rsp_t,
    parameter int  DEPTH = 3,
    parameter int  PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    parameter int  CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  T                 i_push_data,
    input  logic             i_pop,
    output T                 o_head,
    output logic [CNT_W-1:0] o_count
);

    localparam logic [PTR_W-1:0] c_ptr_last = PTR_W'(DEPTH - 1);

    T                 r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == c_ptr_last) ? '0 : p + 1'b1;
    endfunction

    // Storage is not reset: occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (i_push) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
            if (i_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/mem_param_rw.sv
`default_nettype none
// ============================================================================
//  Module      : mem_param_rw
//  Description : Parametrised single-port synchronous memory. It accepts
//                requests through a valid/ready handshake and returns read
//                responses in order with back-pressure. A clear sequencer
//                runs after reset, and out-of-range accesses are reported.
//  Ports       : clk, rst_n                       clock / async active-low reset
//                req_valid/req_ready              request handshake
//                req_we, req_addr, req_wdata, req_be  request payload
//                rsp_valid/rsp_ready              response handshake
//                rsp_rdata, rsp_err               response payload
//                wr_err                           out-of-range write pulse
//                init_done                        clear sequence finished
//  Revision    : 1.0  initial release
// ============================================================================
module mem_param_rw
    import mem_param_rw_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int DEPTH  = 16,
    parameter int RD_LAT = 2,
    parameter int ADDR_W = $clog2(DEPTH),
    parameter int BE_W   = WIDTH / 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [WIDTH-1:0]  req_wdata,
    input  logic [BE_W-1:0]   req_be,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [WIDTH-1:0]  rsp_rdata,
    output logic              rsp_err,
    output logic              wr_err,
    output logic              init_done
);

    localparam int BUF_DEPTH = RD_LAT + 1;
    localparam int CNT_W     = $clog2(BUF_DEPTH + 1);

    localparam logic [ADDR_W-1:0] c_clr_last = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W:0]   c_depth    = (ADDR_W + 1)'(DEPTH);
    localparam logic [CNT_W-1:0]  c_out_max  = CNT_W'(BUF_DEPTH);

    typedef struct packed {
        logic [WIDTH-1:0] rdata;
        logic             err;
    } rsp_t;

    mem_state_e        r_state;
    mem_state_e        w_state_nxt;
    logic [ADDR_W-1:0] r_clr_ptr;
    logic [WIDTH-1:0]  r_mem [DEPTH];
    logic [CNT_W-1:0]  r_outstanding;
    logic              r_wr_err;

    logic              w_run;
    logic              w_oob;
    logic              w_acc;
    logic              w_rd_acc;
    logic              w_wr_acc;
    logic              w_pop;
    logic              w_push;
    rsp_t              w_rd_rsp;
    rsp_t              w_push_data;
    rsp_t              w_head;
    logic [CNT_W-1:0]  w_fifo_cnt;

    // ------------------------------------------------------------------
    // Clear sequencer / run state
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= CLEAR;
            r_clr_ptr <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == CLEAR) begin
                r_clr_ptr <= r_clr_ptr + 1'b1;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_run       = 1'b0;
        case (r_state)
            CLEAR: begin
                if (r_clr_ptr == c_clr_last) w_state_nxt = RUN;
            end
            RUN: begin
                w_run = 1'b1;
            end
            default: w_state_nxt = CLEAR;
        endcase
    end

    // ------------------------------------------------------------------
    // Request acceptance
    // ------------------------------------------------------------------
    // Reads in flight are bounded by the buffer depth, so the buffer
    // never overflows. Writes share the same gate to keep the port simple.
    assign req_ready = w_run && (r_outstanding < c_out_max);
    assign w_acc     = req_valid && req_ready;
    assign w_rd_acc  = w_acc && !req_we;
    assign w_wr_acc  = w_acc &&  req_we;
    assign w_oob     = ({1'b0, req_addr} >= c_depth);

    // ------------------------------------------------------------------
    // Storage: clear sweep has priority; requests are blocked meanwhile
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (r_state == CLEAR) begin
            r_mem[r_clr_ptr] <= '0;
        end else if (w_wr_acc && !w_oob) begin
            for (int b = 0; b < BE_W; b++) begin
                if (req_be[b]) begin
                    r_mem[req_addr][8*b +: 8] <= req_wdata[8*b +: 8];
                end
            end
        end
    end

    // An out-of-range read returns zero data and never indexes the array.
    assign w_rd_rsp.rdata = w_oob ? '0 : r_mem[req_addr];
    assign w_rd_rsp.err   = w_oob;

    // ------------------------------------------------------------------
    // Read latency pipeline: RD_LAT-1 stages in front of the buffer
    // ------------------------------------------------------------------
    if (RD_LAT == 1) begin : g_lat1
        assign w_push      = w_rd_acc;
        assign w_push_data = w_rd_rsp;
    end else begin : g_pipe
        logic [RD_LAT-2:0] r_pv;
        rsp_t              r_pd [RD_LAT-1];

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_pv <= '0;
            end else begin
                r_pv[0] <= w_rd_acc;
                for (int s = 1; s < RD_LAT - 1; s++) begin
                    r_pv[s] <= r_pv[s-1];
                end
            end
        end

        always_ff @(posedge clk) begin
            if (w_rd_acc) r_pd[0] <= w_rd_rsp;
            for (int s = 1; s < RD_LAT - 1; s++) begin
                if (r_pv[s-1]) r_pd[s] <= r_pd[s-1];
            end
        end

        assign w_push      = r_pv[RD_LAT-2];
        assign w_push_data = r_pd[RD_LAT-2];
    end

    // ------------------------------------------------------------------
    // Response buffer and outstanding count
    // ------------------------------------------------------------------
    mem_rsp_fifo #(
        .T     (rsp_t),
        .DEPTH (BUF_DEPTH)
    ) u_rsp_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_push      (w_push),
        .i_push_data (w_push_data),
        .i_pop       (w_pop),
        .o_head      (w_head),
        .o_count     (w_fifo_cnt)
    );

    assign rsp_valid = (w_fifo_cnt != '0);
    assign w_pop     = rsp_valid && rsp_ready;
    // The buffer storage is not reset, so the payload is forced to zero
    // while no response is present.
    assign rsp_rdata = rsp_valid ? w_head.rdata : '0;
    assign rsp_err   = rsp_valid & w_head.err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_outstanding <= '0;
            r_wr_err      <= 1'b0;
        end else begin
            case ({w_rd_acc, w_pop})
                2'b10:   r_outstanding <= r_outstanding + 1'b1;
                2'b01:   r_outstanding <= r_outstanding - 1'b1;
                default: r_outstanding <= r_outstanding;
            endcase
            r_wr_err <= w_wr_acc && w_oob;
        end
    end

    assign wr_err    = r_wr_err;
    assign init_done = w_run;

endmodule
`default_nettype wire

// File: tb/tb_mem_param_rw.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_param_rw
//  Description : Self-checking bench for mem_param_rw (DEPTH=12, RD_LAT=2).
//                A reference model tracks word contents and the queue of
//                accepted reads with their due cycles. The model predicts
//                readiness, response timing and data from those alone.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mem_param_rw;

    localparam int WIDTH  = 32;
    localparam int DEPTH  = 12;
    localparam int RD_LAT = 2;
    localparam int ADDR_W = $clog2(DEPTH);
    localparam int BE_W   = WIDTH / 8;

    logic              clk       = 1'b0;
    logic              rst_n     = 1'b0;
    logic              req_valid = 1'b0;
    logic              req_we    = 1'b0;
    logic [ADDR_W-1:0] req_addr  = '0;
    logic [WIDTH-1:0]  req_wdata = '0;
    logic [BE_W-1:0]   req_be    = '0;
    logic              rsp_ready = 1'b0;
    logic              req_ready;
    logic              rsp_valid;
    logic [WIDTH-1:0]  rsp_rdata;
    logic              rsp_err;
    logic              wr_err;
    logic              init_done;

    always #5 clk = ~clk;

    mem_param_rw #(
        .WIDTH  (WIDTH),
        .DEPTH  (DEPTH),
        .RD_LAT (RD_LAT)
    ) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_be    (req_be),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .wr_err    (wr_err),
        .init_done (init_done)
    );

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        int               due;
        logic [WIDTH-1:0] data;
        logic             err;
    } exp_t;

    exp_t             q[$];
    logic [WIDTH-1:0] mdl [DEPTH];
    int               cyc       = 0;
    int               since     = 0;
    bit               pend_werr = 1'b0;
    int               n_dut_acc = 0;

    task automatic model_reset();
        q.delete();
        foreach (mdl[i]) mdl[i] = '0;
        since     = 0;
        pend_werr = 1'b0;
    endtask

    // Inputs are already set; check outputs at the falling edge, advance the
    // model as if the coming rising edge happens, then move past that edge.
    task automatic step();
        bit   exp_init, exp_rdy, exp_rv, oob, acc;
        int   n_due;
        exp_t e;
        @(negedge clk);
        if (!rst_n) begin
            chk("rst_rsp_valid", rsp_valid, 0);
            chk("rst_req_ready", req_ready, 0);
            chk("rst_init_done", init_done, 0);
            chk("rst_wr_err",    wr_err,    0);
            chk("rst_rdata",     rsp_rdata, 0);
            model_reset();
        end else begin
            if (req_valid && req_ready) n_dut_acc++;
            exp_init = (since >= DEPTH);
            exp_rdy  = exp_init && (q.size() < RD_LAT + 1);
            chk("init_done", init_done, exp_init);
            chk("req_ready", req_ready, exp_rdy);
            chk("wr_err",    wr_err,    pend_werr);
            n_due = 0;
            foreach (q[i]) if (q[i].due <= cyc) n_due++;
            chk("buf_occ", u_dut.w_fifo_cnt, n_due);
            exp_rv = (q.size() > 0) && (q[0].due <= cyc);
            chk("rsp_valid", rsp_valid, exp_rv);
            if (exp_rv) begin
                chk("rsp_rdata", rsp_rdata, q[0].data);
                chk("rsp_err",   rsp_err,   q[0].err);
                if (rsp_ready) void'(q.pop_front());
            end
            oob       = (int'(req_addr) >= DEPTH);
            acc       = req_valid && exp_rdy;
            pend_werr = acc && req_we && oob;
            if (acc && req_we && !oob) begin
                for (int b = 0; b < BE_W; b++)
                    if (req_be[b]) mdl[req_addr][8*b +: 8] = req_wdata[8*b +: 8];
            end
            if (acc && !req_we) begin
                e.due  = cyc + RD_LAT;
                e.data = oob ? '0 : mdl[req_addr];
                e.err  = oob;
                q.push_back(e);
            end
            since++;
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit v, input bit we, input int a,
                         input logic [WIDTH-1:0] d, input logic [BE_W-1:0] be,
                         input bit rr);
        req_valid = v;
        req_we    = we;
        req_addr  = ADDR_W'(a);
        req_wdata = d;
        req_be    = be;
        rsp_ready = rr;
    endtask

    task automatic idle(input int n);
        drive(0, 0, 0, '0, '0, 1);
        repeat (n) step();
    endtask

    initial begin
        int acc0;
        model_reset();
        rst_n = 1'b0;
        repeat (3) step();
        rst_n = 1'b1;

        // Clear sequence: init_done must rise after exactly DEPTH edges.
        idle(DEPTH + 2);

        // Every word reads back zero after the clear.
        for (int a = 0; a < DEPTH; a++) begin
            drive(1, 0, a, '0, '0, 1);
            step();
        end
        idle(RD_LAT + 2);

        // Byte-lane merge and read-after-write.
        drive(1, 1, 5, 32'hDEADBEEF, 4'b1111, 1); step();
        drive(1, 1, 5, 32'h00000011, 4'b0001, 1); step();
        drive(1, 0, 5, '0, '0, 1);                step();
        idle(4);

        // Out-of-range write and read, then confirm memory unchanged.
        drive(1, 1, 13, 32'hA5A5A5A5, 4'b1111, 1); step();
        drive(1, 0, 13, '0, '0, 1);                step();
        for (int a = 0; a < DEPTH; a++) begin
            drive(1, 0, a, '0, '0, 1);
            step();
        end
        idle(4);

        // Back-pressure: 5 back-to-back reads against a stalled consumer.
        acc0 = n_dut_acc;
        for (int i = 0; i < 5; i++) begin
            drive(1, 0, i, '0, '0, 0);
            step();
        end
        chk("bp_accepted", n_dut_acc - acc0, 3);
        drive(0, 0, 0, '0, '0, 0);
        step();
        idle(5);

        // Streaming: 100 back-to-back reads with an always-ready consumer.
        acc0 = n_dut_acc;
        for (int i = 0; i < 100; i++) begin
            drive(1, 0, $urandom_range(0, DEPTH - 1), '0, '0, 1);
            step();
        end
        chk("stream_accepted", n_dut_acc - acc0, 100);
        idle(4);

        // Randomised mix including out-of-range addresses and stalls.
        for (int i = 0; i < 300; i++) begin
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
                  $urandom_range(0, 15), $urandom, BE_W'($urandom_range(0, 15)),
                  $urandom_range(0, 3) != 0);
            step();
        end
        idle(8);

        // Reset with reads in flight: no stale response, memory cleared again.
        drive(1, 0, 1, '0, '0, 1); step();
        drive(1, 0, 2, '0, '0, 1); step();
        rst_n = 1'b0;
        #1;
        chk("async_rsp_valid", rsp_valid, 0);
        chk("async_init_done", init_done, 0);
        drive(0, 0, 0, '0, '0, 1);
        repeat (2) step();
        rst_n = 1'b1;
        idle(DEPTH + 3);
        for (int a = 0; a < 6; a++) begin
            drive(1, 0, a, '0, '0, 1);
            step();
        end
        idle(5);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_param_rw.md
Name: mem_param_rw

Overview:
- Parametrised single-port synchronous memory; next generation of the fixed 16x32 memory used by the class-based environment.
- Generalised in width, depth, read latency and byte-lane granularity.
- Adds a valid/ready request/response handshake with back-pressure, a power-on clear sequencer, and out-of-range address detection.
- Sits behind the memory interface and is driven by the class-based environment's driver and monitor.

Parameters:
- WIDTH, 32, data word width in bits; must be a multiple of 8.
- DEPTH, 16, number of words; need not be a power of two.
- RD_LAT, 2, request-accept to rsp_valid latency for reads, 1..4.
- ADDR_W, $clog2(DEPTH), address width (derived; do not override).
- BE_W, WIDTH/8, byte-enable width (derived).

Ports:
- clk  in  1  clock, rising edge active.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  block accepts request this cycle.
- req_we  in  1  1=write, 0=read.
- req_addr  in  ADDR_W  word address.
- req_wdata  in  WIDTH  write data.
- req_be  in  BE_W  byte enables for writes; ignored on reads.
- rsp_valid  out  1  read response present.
- rsp_ready  in  1  consumer accepts response.
- rsp_rdata  out  WIDTH  read data.
- rsp_err  out  1  response belongs to an out-of-range read.
- wr_err  out  1  one-cycle pulse: out-of-range write dropped.
- init_done  out  1  clear sequence finished.

Behaviour:
- Reset: async assert on rst_n low. All outputs 0, pipeline and response buffer emptied, state <= CLEAR, clear pointer <= 0.
- FSM CLEAR:
  - Writes 0 to word[ptr] each cycle; ptr++.
  - Exits to RUN after word DEPTH-1 is written, so exactly DEPTH cycles after reset release.
  - req_ready=0 and init_done=0 throughout.
- FSM RUN: init_done=1. Transfer occurs when req_valid && req_ready. The FSM never returns to CLEAR except via reset.
- Write:
  - Applied at the accepting edge: byte lane i is updated only where req_be[i]=1.
  - No response is generated.
  - If req_addr >= DEPTH, memory is unchanged and wr_err pulses high the next cycle.
- Read:
  - Data is sampled from the array at the accepting edge, then delayed through an RD_LAT-1 stage valid pipeline into the response buffer.
  - For RD_LAT=1, rsp_valid rises the cycle after acceptance when the buffer is empty.
  - If req_addr >= DEPTH: rsp_rdata=0 and rsp_err=1.
- Ordering:
  - Responses are returned strictly in request order.
  - A read accepted the cycle after a write to the same address returns the new data. Single port, so there is no same-cycle read/write.
- Back-pressure:
  - Response buffer depth is RD_LAT+1.
  - An outstanding counter covers reads in the pipeline plus reads in the buffer. It increments on read accept and decrements on rsp_valid && rsp_ready; both in the same cycle leave it unchanged.
  - req_ready = (state==RUN) && (outstanding < RD_LAT+1). Writes are also blocked when this is low, so the port stays simple.
  - Overflow is impossible by construction; the bench asserts that it never happens.
- Response outputs: rsp_valid/rsp_rdata/rsp_err hold stable while rsp_valid && !rsp_ready.
- Full throughput: with rsp_ready held at 1, one read is accepted per cycle indefinitely.
- Reset mid-operation: in-flight reads are discarded with no response, and memory is cleared again.
- Address wrap: none. Addresses >= DEPTH never alias to valid words.

Decomposition:
- Package pack (shared with the environment) holds:
  - typedef struct mem_req_t {we, addr, wdata, be}
  - typedef struct mem_rsp_t {rdata, err}
  - typedef enum {CLEAR, RUN} mem_state_e
  - MAX_RD_LAT = 4
- Sub-module mem_rsp_fifo: parametrised synchronous FIFO of mem_rsp_t with depth RD_LAT+1, plus count output. It is reusable by the environment's scoreboard model.

Test Plan:
- Release reset with DEPTH=16 -> init_done rises exactly 16 cycles later; read of every address returns 0 with rsp_err=0.
- Write addr 5, data 0xDEADBEEF, be=4'b1111, then write addr 5, data 0x00000011, be=4'b0001, then read 5 -> rsp_rdata=0xDEADBE11 arrives RD_LAT=2 cycles after acceptance.
- DEPTH=12 (ADDR_W=4): write addr 13 -> wr_err pulses once, memory unchanged; read addr 13 -> rsp_err=1, rsp_rdata=0.
- Back-pressure with rsp_ready=0 and 5 back-to-back reads at RD_LAT=2 -> exactly 3 accepted, then req_ready=0. Raising rsp_ready then drains 3 responses in order, and req_ready returns to 1 after the first drain.
- Streaming 100 back-to-back reads with rsp_ready=1 -> one response per cycle with no bubbles after the first RD_LAT cycles; data matches the scoreboard.
- Assert rst_n low with 2 reads in flight -> rsp_valid=0 immediately; after release, init_done=0 for DEPTH cycles and no stale response appears.
